// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller: 16 lines, external tag/data array,
// single-outstanding miss fill from memory, with saturating hit/miss statistics.
module cache_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [TAG_W+IDX_W-1:0]   req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_hit,
  output logic                     mem_req,
  output logic [TAG_W+IDX_W-1:0]   mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     sram_we,
  output logic [(1<<IDX_W)-1:0]    sram_wl,
  output logic [TAG_W-1:0]         sram_tag_in,
  output logic [DATA_W-1:0]        sram_data_in,
  input  logic [TAG_W-1:0]         sram_tag_out,
  input  logic [DATA_W-1:0]        sram_data_out,
  output logic [7:0]               hit_cnt,
  output logic [7:0]               miss_cnt
);

  localparam int unsigned AddrW = TAG_W + IDX_W;
  localparam int unsigned Lines = 1 << IDX_W;

  typedef enum logic [2:0] {StIdle, StLookup, StMiss, StFill, StResp} state_e;

  state_e             r_state, w_state_d;
  logic [AddrW-1:0]   r_addr;
  logic [Lines-1:0]   r_valid;
  logic [DATA_W-1:0]  r_fill;
  logic [DATA_W-1:0]  r_resp_data;
  logic               r_resp_hit;
  logic [7:0]         r_hit_cnt;
  logic [7:0]         r_miss_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_accept;

  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_tag    = r_addr[AddrW-1:IDX_W];
  assign w_hit    = r_valid[w_idx] && (sram_tag_out == w_tag);
  assign w_accept = req_valid && req_ready;

  assign req_ready    = (r_state == StIdle) && !flush;
  assign resp_valid   = (r_state == StResp);
  assign resp_data    = r_resp_data;
  assign resp_hit     = r_resp_hit;
  assign mem_req      = (r_state == StMiss);
  assign mem_addr     = r_addr;
  assign sram_we      = (r_state == StFill);
  // Wordline always tracks the latched index so the array read is valid in LOOKUP.
  assign sram_wl      = {{(Lines-1){1'b0}}, 1'b1} << w_idx;
  assign sram_tag_in  = w_tag;
  assign sram_data_in = r_fill;
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_accept) w_state_d = StLookup;
      StLookup: w_state_d = w_hit ? StResp : StMiss;
      StMiss:   if (mem_ack) w_state_d = StFill;
      StFill:   w_state_d = StResp;
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_valid     <= '0;
      r_fill      <= '0;
      r_resp_data <= '0;
      r_resp_hit  <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (flush) r_valid <= '0;
          else if (w_accept) r_addr <= req_addr;
        end
        StLookup: begin
          if (w_hit) begin
            r_resp_data <= sram_data_out;
            r_resp_hit  <= 1'b1;
            if (r_hit_cnt != 8'hFF) r_hit_cnt <= r_hit_cnt + 8'd1;
          end else if (r_miss_cnt != 8'hFF) begin
            r_miss_cnt <= r_miss_cnt + 8'd1;
          end
        end
        StMiss: if (mem_ack) r_fill <= mem_data;
        StFill: begin
          r_valid[w_idx] <= 1'b1;
          r_resp_data    <= r_fill;
          r_resp_hit     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl: a behavioural cache model predicts each
// response and array write; a negedge monitor pops and compares them as the DUT emits them.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_hit;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        sram_we;
  logic [15:0] sram_wl;
  logic [3:0]  sram_tag_in;
  logic [7:0]  sram_data_in;
  logic [3:0]  sram_tag_out;
  logic [7:0]  sram_data_out;
  logic [7:0]  hit_cnt;
  logic [7:0]  miss_cnt;

  cache_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_hit(resp_hit), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .sram_we(sram_we), .sram_wl(sram_wl), .sram_tag_in(sram_tag_in),
    .sram_data_in(sram_data_in), .sram_tag_out(sram_tag_out),
    .sram_data_out(sram_data_out), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tag/data array with a combinational read through the one-hot wordline.
  logic [3:0] mtag [16];
  logic [7:0] mdat [16];
  always @(posedge clk) begin
    if (sram_we) begin
      for (int i = 0; i < 16; i++) begin
        if (sram_wl[i]) begin
          mtag[i] <= sram_tag_in;
          mdat[i] <= sram_data_in;
        end
      end
    end
  end
  always_comb begin
    sram_tag_out  = '0;
    sram_data_out = '0;
    for (int i = 0; i < 16; i++) begin
      if (sram_wl[i]) begin
        sram_tag_out  = mtag[i];
        sram_data_out = mdat[i];
      end
    end
  end

  typedef struct {logic [7:0] data; logic hit; logic [7:0] hcnt; logic [7:0] mcnt;} resp_t;
  typedef struct {logic [15:0] wl; logic [3:0] tag; logic [7:0] data;} fill_t;
  resp_t resp_q[$];
  fill_t fill_q[$];
  int unsigned exp_ref_cyc = 0;

  // Reference cache: plain arrays and counters.
  bit         ref_valid [16];
  logic [3:0] ref_tag   [16];
  logic [7:0] ref_data  [16];
  int         ref_hits = 0;
  int         ref_misses = 0;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  function automatic logic [7:0] sat8(input int x);
    return (x > 255) ? 8'hFF : x[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    resp_t e;
    fill_t f;
    if (mon_en) begin
      chk("wl_onehot", 32'($onehot(sram_wl)), 32'd1);
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = resp_q.pop_front();
          chk("resp_data", 32'(resp_data), 32'(e.data));
          chk("resp_hit", 32'(resp_hit), 32'(e.hit));
          chk("hit_cnt", 32'(hit_cnt), 32'(e.hcnt));
          chk("miss_cnt", 32'(miss_cnt), 32'(e.mcnt));
          chk("resp_latency", cyc - exp_ref_cyc, 32'd2);
        end
      end
      if (sram_we) begin
        if (fill_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          f = fill_q.pop_front();
          chk("fill_wl", 32'(sram_wl), 32'(f.wl));
          chk("fill_tag", 32'(sram_tag_in), 32'(f.tag));
          chk("fill_data", 32'(sram_data_in), 32'(f.data));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [7:0] a, input int dly, input logic [7:0] d);
    logic [3:0] idx;
    logic [3:0] tag;
    bit         hit;
    int         n;
    wait_ready();
    idx = a[3:0];
    tag = a[7:4];
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    req_valid = 1'b1;
    req_addr  = a;
    exp_ref_cyc = cyc;
    if (hit) begin
      ref_hits++;
      resp_q.push_back('{ref_data[idx], 1'b1, sat8(ref_hits), sat8(ref_misses)});
    end else begin
      ref_misses++;
      resp_q.push_back('{d, 1'b0, sat8(ref_hits), sat8(ref_misses)});
      fill_q.push_back('{16'h0001 << idx, tag, d});
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
      ref_data[idx]  = d;
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (hit) begin
      n = 0;
      while (!req_ready && n < 10) begin
        mem_ack  = 1'($urandom_range(0, 1));
        mem_data = 8'($urandom);
        chk("hit_no_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        n++;
      end
      mem_ack = 1'b0;
    end else begin
      n = 0;
      while (!mem_req && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("mem_req_rise", 32'(mem_req), 32'd1);
      for (int k = 1; k <= dly; k++) begin
        chk("mem_addr", 32'(mem_addr), 32'(a));
        if (k == dly) begin
          mem_ack  = 1'b1;
          mem_data = d;
          exp_ref_cyc = cyc;
          @(negedge clk);
          mem_ack  = 1'b0;
          mem_data = 8'($urandom);
          chk("mem_req_drop", 32'(mem_req), 32'd0);
        end else begin
          @(negedge clk);
          chk("mem_req_hold", 32'(mem_req), 32'd1);
        end
      end
    end
  endtask

  task automatic do_flush(input bit with_req, input logic [7:0] a);
    wait_ready();
    flush     = 1'b1;
    req_valid = with_req;
    req_addr  = a;
    #1;
    chk("flush_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush_not_accepted", 32'(req_ready), 32'd1);
    chk("flush_no_mem_req", 32'(mem_req), 32'd0);
    ref_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    ref_clear();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_sram_wl", 32'(sram_wl), 32'h0001);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    mon_en = 1'b1;

    do_read(8'h35, 3, 8'hA7);
    do_read(8'h35, 1, 8'h00);
    do_read(8'h75, 2, 8'h5C);
    do_read(8'h35, 1, 8'hA7);

    do_flush(1'b1, 8'h75);
    do_read(8'h75, 1, 8'h5C);

    // Reset while a fill is outstanding; a late ack must be ignored.
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 8'h12;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 10 && !mem_req; n++) @(negedge clk);
    chk("midmiss_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midmiss_mem_req_drop", 32'(mem_req), 32'd0);
    chk("midmiss_idle", 32'(req_ready), 32'd1);
    chk("midmiss_miss_cnt", 32'(miss_cnt), 32'd0);
    ref_clear();
    ref_hits   = 0;
    ref_misses = 0;
    mem_ack  = 1'b1;
    mem_data = 8'hFF;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    do_read(8'h12, 2, 8'h81);

    for (int i = 0; i < 60; i++) begin
      a = 8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) do_flush(1'($urandom_range(0, 1)), a);
      do_read(a, int'($urandom_range(1, 4)), 8'($urandom));
    end

    do_read(8'hC9, 2, 8'h3E);
    for (int i = 0; i < 300; i++) do_read(8'hC9, 1, 8'h00);
    wait_ready();
    chk("hit_cnt_saturated", 32'(hit_cnt), 32'd255);

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    chk("fill_queue_drained", 32'(fill_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
